// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between register-read response bytes and a periodic
// 4-byte telemetry frame. Requesters are served round-robin at frame
// boundaries; a telemetry frame runs to completion once started.
module uart_tx_arbiter #(
  parameter int          TELEM_PERIOD = 16368,
  parameter logic [7:0]  TELEM_HDR    = 8'hA5
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rd_valid_in,
  input  logic [7:0] rd_data_in,
  output logic       rd_ready_out,
  input  logic       telem_enable_in,
  input  logic [7:0] status_in,
  input  logic [4:0] sat_id_in,
  output logic       tx_dv_out,
  output logic [7:0] tx_data_out,
  input  logic       tx_active_in,
  input  logic       tx_done_in,
  output logic       telem_busy_out,
  output logic       telem_drop_out
);

  localparam int              CNT_W    = $clog2(TELEM_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TELEM_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             pending;
  logic             last_telem;
  logic [1:0]       idx;
  logic [7:0]       data_q;
  logic [7:0]       status_q;
  logic [7:0]       sat_q;
  logic [7:0]       chk_q;

  logic tick;
  logic can_grant;
  logic grant_rd;
  logic grant_telem;
  logic telem_more;
  logic telem_last_gap;

  // Frame checksum: XOR of the three leading bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] hdr,
                                           input logic [7:0] st,
                                           input logic [7:0] sid);
    return hdr ^ st ^ sid;
  endfunction

  assign tick           = telem_enable_in && (cnt == CNT_LAST) && !rst_in;
  assign can_grant      = (state == IDLE) && !tx_active_in && !rst_in;
  // last_telem doubles as "current transfer is telemetry" outside IDLE.
  assign telem_more     = (state == GAP) && last_telem && (idx != 2'd3);
  assign telem_last_gap = (state == GAP) && last_telem && (idx == 2'd3);

  // Round-robin grant between the read byte and a pending frame.
  always_comb begin
    grant_rd    = 1'b0;
    grant_telem = 1'b0;
    if (can_grant) begin
      if (rd_valid_in && pending) begin
        grant_rd    = last_telem;
        grant_telem = !last_telem;
      end else begin
        grant_rd    = rd_valid_in;
        grant_telem = pending;
      end
    end
  end

  // Period counter, held at zero while telemetry is disabled.
  always_ff @(posedge clk_in) begin
    if (rst_in || !telem_enable_in || tick) cnt <= '0;
    else                                    cnt <= cnt + 1'b1;
  end

  // Single-deep frame request; a tick in the start cycle re-arms it.
  always_ff @(posedge clk_in) begin
    if (rst_in || !telem_enable_in) pending <= 1'b0;
    else if (tick)                  pending <= 1'b1;
    else if (grant_telem)           pending <= 1'b0;
  end

  // Remember who was served last for the round-robin tie-break.
  always_ff @(posedge clk_in) begin
    if (rst_in)           last_telem <= 1'b1;
    else if (grant_rd)    last_telem <= 1'b0;
    else if (grant_telem) last_telem <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_rd || grant_telem) state_nxt = LOAD;
      LOAD:    state_nxt = WAIT;
      WAIT:    if (tx_done_in) state_nxt = GAP;
      GAP:     state_nxt = telem_more ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    rd_ready_out   = grant_rd;
    tx_dv_out      = (state == LOAD);
    telem_drop_out = tick && pending && !grant_telem;
    telem_busy_out = grant_telem ||
                     (last_telem && (state != IDLE) && !telem_last_gap);
  end

  // Frame byte index, advanced in the gap between bytes.
  always_ff @(posedge clk_in) begin
    if (rst_in || grant_telem) idx <= 2'd0;
    else if (telem_more)       idx <= idx + 2'd1;
  end

  // Byte presented to uart_tx; loaded at grant or in the inter-byte gap.
  always_ff @(posedge clk_in) begin
    if (rst_in)           data_q <= 8'h00;
    else if (grant_rd)    data_q <= rd_data_in;
    else if (grant_telem) data_q <= TELEM_HDR;
    else if (telem_more) begin
      case (idx)
        2'd0:    data_q <= status_q;
        2'd1:    data_q <= sat_q;
        default: data_q <= chk_q;
      endcase
    end
  end

  // Frame snapshot taken in the grant cycle.
  always_ff @(posedge clk_in) begin
    if (grant_telem) begin
      status_q <= status_in;
      sat_q    <= {3'b000, sat_id_in};
      chk_q    <= frame_chk(TELEM_HDR, status_in, {3'b000, sat_id_in});
    end
  end

  assign tx_data_out = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: randomized and directed stimulus, a uart_tx
// stand-in with programmable done delay, and a transaction-level model
// checked against the DUT on every cycle.
module tb_uart_tx_arbiter;

  localparam int PERIOD = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_valid = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       rd_ready;
  logic       en = 1'b0;
  logic [7:0] status = 8'h00;
  logic [4:0] sat = 5'd0;
  logic       tx_dv;
  logic [7:0] tx_data;
  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;
  logic       busy;
  logic       drop;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  uart_tx_arbiter #(.TELEM_PERIOD(PERIOD), .TELEM_HDR(8'hA5)) dut (
    .clk_in(clk), .rst_in(rst),
    .rd_valid_in(rd_valid), .rd_data_in(rd_data), .rd_ready_out(rd_ready),
    .telem_enable_in(en), .status_in(status), .sat_id_in(sat),
    .tx_dv_out(tx_dv), .tx_data_out(tx_data),
    .tx_active_in(tx_active), .tx_done_in(tx_done),
    .telem_busy_out(busy), .telem_drop_out(drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // uart_tx stand-in: done pulse uart_delay cycles after the dv cycle.
  int uart_delay = 10;
  int u_dv_at = -1000;
  int u_done_at = -1000;
  always @(negedge clk) begin
    if (tx_dv === 1'b1) begin
      u_dv_at   = cyc;
      u_done_at = cyc + uart_delay;
    end
  end
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_done   = (cyc == u_done_at);
      tx_active = (cyc > u_dv_at) && (cyc <= u_done_at);
    end
  end

  // Transaction model: a transfer owns the uart from grant until the
  // cycle after the gap that follows its last done.
  int         m_cnt = 0;
  bit         m_pend = 0, m_last_t = 1, m_own = 0, m_is_t = 0, m_await = 0;
  int         m_dv_at = -1, m_gap_at = -1;
  logic [7:0] m_bytes[$];
  logic [7:0] m_data = 8'h00;

  int dv_log[$];
  int dv_cyc_log[$];
  int rd_cyc_log[$];
  int drop_cnt = 0, busy_cnt = 0, busy_rise = 0;
  bit busy_prev = 0;

  always @(negedge clk) begin : compare
    bit tick, can, g_rd, g_t, e_dv, e_busy, e_drop;
    if (rst) begin
      chk("rst_rd_ready", int'(rd_ready), 0);
      chk("rst_drop", int'(drop), 0);
      m_cnt = 0; m_pend = 0; m_last_t = 1; m_own = 0; m_is_t = 0; m_await = 0;
      m_dv_at = -1; m_gap_at = -1; m_bytes.delete(); m_data = 8'h00;
      busy_prev = 0;
    end else begin
      tick   = en && (m_cnt == PERIOD - 1);
      can    = !m_own && !tx_active;
      g_rd   = can && rd_valid && (!m_pend || m_last_t);
      g_t    = can && m_pend && (!rd_valid || !m_last_t);
      e_dv   = m_own && (cyc == m_dv_at);
      e_busy = g_t || (m_own && m_is_t && !((cyc == m_gap_at) && (m_bytes.size() == 0)));
      e_drop = tick && m_pend && !g_t;

      chk("rd_ready", int'(rd_ready), int'(g_rd));
      chk("tx_dv", int'(tx_dv), int'(e_dv));
      chk("tx_data", int'(tx_data), int'(m_data));
      chk("telem_busy", int'(busy), int'(e_busy));
      chk("telem_drop", int'(drop), int'(e_drop));

      if (rd_ready) rd_cyc_log.push_back(cyc);
      if (tx_dv) begin
        dv_log.push_back(int'(tx_data));
        dv_cyc_log.push_back(cyc);
      end
      if (drop) drop_cnt++;
      if (busy) busy_cnt++;
      if (busy && !busy_prev) busy_rise++;
      busy_prev = busy;

      if (m_own && m_await && tx_done) begin
        m_await  = 0;
        m_gap_at = cyc + 1;
      end
      if (m_own && (cyc == m_gap_at)) begin
        if (m_bytes.size() != 0) begin
          m_data  = m_bytes.pop_front();
          m_dv_at = cyc + 1;
        end else begin
          m_own = 0;
        end
      end
      if (m_own && (cyc == m_dv_at)) m_await = 1;
      if (g_rd) begin
        m_own = 1; m_is_t = 0; m_last_t = 0;
        m_data = rd_data; m_dv_at = cyc + 1; m_bytes.delete();
      end
      if (g_t) begin
        m_own = 1; m_is_t = 1; m_last_t = 1;
        m_data = 8'hA5; m_dv_at = cyc + 1;
        m_bytes = '{status, {3'b000, sat}, 8'hA5 ^ status ^ {3'b000, sat}};
      end
      if (!en)       m_pend = 0;
      else if (tick) m_pend = 1;
      else if (g_t)  m_pend = 0;
      if (!en || tick) m_cnt = 0;
      else             m_cnt = m_cnt + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, e, b, bd, brise, bbusy, max_gap;

    // Reset, then idle with telemetry disabled.
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(200);
    chk("idle_dv_count", dv_log.size(), 0);
    chk("idle_rd_count", rd_cyc_log.size(), 0);

    // Single read byte, then a back-to-back second read.
    b = dv_log.size();
    n = cyc;
    rd_valid = 1'b1; rd_data = 8'h3C;
    step(1);
    rd_data = 8'h5A;
    step(13);
    rd_valid = 1'b0;
    step(20);
    chk("rd1_ready_cycle", qget(rd_cyc_log, 0) - n, 0);
    chk("rd1_dv_cycle", qget(dv_cyc_log, b) - n, 1);
    chk("rd1_byte", qget(dv_log, b), 8'h3C);
    chk("rd2_ready_cycle", qget(rd_cyc_log, 1) - n, 13);
    chk("rd2_byte", qget(dv_log, b + 1), 8'h5A);

    // One telemetry frame with known contents.
    b = dv_log.size(); bbusy = busy_cnt;
    status = 8'h01; sat = 5'd17;
    e = cyc;
    en = 1'b1;
    step(124);
    en = 1'b0;
    step(10);
    chk("frm_first_dv", qget(dv_cyc_log, b) - e, 65);
    chk("frm_byte0", qget(dv_log, b), 8'hA5);
    chk("frm_byte1", qget(dv_log, b + 1), 8'h01);
    chk("frm_byte2", qget(dv_log, b + 2), 8'h11);
    chk("frm_byte3", qget(dv_log, b + 3), 8'hB5);
    chk("frm_busy_cycles", busy_cnt - bbusy, 48);

    // Continuous reads with random data competing with telemetry.
    b = rd_cyc_log.size(); bd = drop_cnt; brise = busy_rise;
    en = 1'b1; rd_valid = 1'b1;
    for (int i = 0; i < 620; i++) begin
      rd_data = 8'($urandom);
      status  = 8'($urandom);
      sat     = 5'($urandom);
      step(1);
    end
    rd_valid = 1'b0; en = 1'b0;
    step(100);
    max_gap = 0;
    for (int i = b + 1; i < rd_cyc_log.size(); i++)
      if (rd_cyc_log[i] - rd_cyc_log[i-1] > max_gap) max_gap = rd_cyc_log[i] - rd_cyc_log[i-1];
    chk("mix_drops", drop_cnt - bd, 0);
    chk("mix_frames", busy_rise - brise, 9);
    chk("mix_read_gap_ok", int'(max_gap <= 62 && max_gap >= 13), 1);

    // Slow uart: ticks during a long frame are dropped, one frame queued.
    b = dv_log.size(); bd = drop_cnt; brise = busy_rise;
    uart_delay = 200;
    status = 8'h3C; sat = 5'd2;
    e = cyc;
    en = 1'b1;
    step(880);
    en = 1'b0;
    step(840);
    uart_delay = 10;
    chk("slow_drops", drop_cnt - bd, 11);
    chk("slow_frames", busy_rise - brise, 2);
    chk("slow_dv_count", dv_log.size() - b, 8);
    chk("slow_second_dv", qget(dv_cyc_log, b + 4) - e, 874);
    chk("slow_second_hdr", qget(dv_log, b + 4), 8'hA5);

    // Reset in the middle of frame byte 2.
    b = dv_log.size();
    status = 8'h55; sat = 5'd9;
    e = cyc;
    en = 1'b1;
    step(92);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_dv", int'(tx_dv), 0);
    chk("rstmid_data", int'(tx_data), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_ready", int'(rd_ready), 0);
    chk("rstmid_drop", int'(drop), 0);
    step(130);
    en = 1'b0;
    step(20);
    chk("rstmid_pre_bytes", qget(dv_cyc_log, b + 2) - e, 89);
    chk("rstmid_next_dv", qget(dv_cyc_log, b + 3) - e, 158);
    chk("rstmid_next_hdr", qget(dv_log, b + 3), 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single register-bank UART transmitter between two requesters: register-read response bytes and a periodic 4-byte telemetry frame.
- Owns the byte-level handshake to uart_tx: a one-cycle data-valid pulse, then waits for done.
- Schedules requesters round-robin at frame boundaries; a telemetry frame is atomic once started.

Parameters:
TELEM_PERIOD, 16368, clocks between telemetry ticks (1 ms at 16.368 MHz); must be >= 2.
TELEM_HDR, 8'hA5, first byte of every telemetry frame.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-high reset
rd_valid_in  input  1  register-read response byte available
rd_data_in  input  8  register-read response byte
rd_ready_out  output  1  one-cycle pulse: rd_data_in accepted this cycle
telem_enable_in  input  1  enables periodic telemetry
status_in  input  8  status byte, snapshotted at frame start
sat_id_in  input  5  satellite id, snapshotted at frame start
tx_dv_out  output  1  one-cycle start pulse to uart_tx
tx_data_out  output  8  byte to uart_tx, stable from the tx_dv_out cycle until tx_done_in
tx_active_in  input  1  uart_tx busy
tx_done_in  input  1  uart_tx one-cycle done pulse
telem_busy_out  output  1  high from telemetry frame start until its last byte is done
telem_drop_out  output  1  one-cycle pulse: tick lost because a frame was already pending

Behaviour:
- Interface: one clock, clk_in; reset rst_in is synchronous and active-high.
- Reset values:
  - Outputs: rd_ready_out=0, tx_dv_out=0, tx_data_out=8'h00, telem_busy_out=0, telem_drop_out=0.
  - Internal: state=IDLE, period counter=0, pending=0, last_grant=TELEM, byte index=0.
- Reset mid-operation aborts any byte or frame in progress. A sync reset takes priority over every other event in that cycle.
- Period counter:
  - Counts 0..TELEM_PERIOD-1 while telem_enable_in=1. Tick in the cycle it equals TELEM_PERIOD-1, then wraps to 0.
  - While telem_enable_in=0 the counter is held at 0 and pending is cleared. A frame already started completes.
- Pending flag:
  - Set on tick. Cleared when a frame starts.
  - Tick while pending=1 gives telem_drop_out=1 for that cycle; pending stays 1, so only one frame is queued.
  - Tick in the same cycle as the frame start: the frame starts, pending stays set, no drop.
- FSM states: IDLE, LOAD, WAIT, GAP.
- IDLE, grant only when tx_active_in=0:
  - Candidates: rd_valid_in=1, pending=1.
  - Both present: grant the one not granted last (round-robin). One present: grant it. last_grant updates on grant.
  - Read grant: rd_ready_out=1 in that cycle, rd_data_in captured; go to LOAD.
  - Telemetry grant: snapshot the frame, index=0, telem_busy_out=1; go to LOAD.
  - No grant: stay in IDLE.
- Telemetry frame bytes:
  - Byte 0 = TELEM_HDR; byte 1 = status_in; byte 2 = {3'b000, sat_id_in}.
  - Byte 3 = XOR of bytes 0..2.
  - All sampled in the grant cycle.
- LOAD: tx_dv_out=1 for exactly one cycle, tx_data_out = current byte; go to WAIT.
  - Latency: grant at cycle N gives tx_dv_out at N+1.
- WAIT: hold tx_data_out; on tx_done_in=1 go to GAP. No timeout.
- GAP: one idle cycle so uart_tx can return to idle. Then:
  - Telemetry with index<3: index++, go to LOAD; the frame is not interruptible.
  - Telemetry with index=3: telem_busy_out=0 in this cycle, go to IDLE.
  - Read byte: go to IDLE.
- tx_done_in outside WAIT is ignored. rd_ready_out is never asserted outside an IDLE grant.

Test Plan:
- Bench setup for all scenarios: TELEM_PERIOD=64; uart_tx model asserts tx_done_in 10 cycles after tx_dv_out.
- Reset then idle, telem_enable_in=0 for 200 cycles -> no tx_dv_out; all outputs 0.
- rd_valid_in=1, rd_data_in=8'h3C at cycle N, telem disabled -> rd_ready_out at N, tx_dv_out at N+1 with tx_data_out=8'h3C; stable until tx_done_in; next grant possible no earlier than done+2.
- telem_enable_in=1, status_in=8'h01, sat_id_in=5'd17 -> bytes A5,01,11,B5 in order, four tx_dv_out pulses; telem_busy_out spans the frame.
- Read request held continuously with telemetry enabled -> grants alternate read/frame; every tick produces a full frame; no read waits for more than one frame.
- uart model delays tx_done_in by 200 cycles -> telem_drop_out pulses once per extra tick; exactly one queued frame is sent afterwards.
- rst_in asserted during frame byte 2 -> next cycle all outputs 0, counter 0; first frame after release follows 64 cycles later.
